// File: rtl/bracket_scan_ctrl.sv
// Loop-skip sequencer: steps the PC Counter one address at a time to the matching
// bracket, tracking nesting depth, and reports done / error as one-cycle pulses.
module bracket_scan_ctrl #(
  parameter int              IW       = 8,
  parameter int              DW       = 8,
  parameter logic [IW-1:0]   OP_OPEN  = 8'h5B,
  parameter logic [IW-1:0]   OP_CLOSE = 8'h5D
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          dir,
  input  logic          abort,
  input  logic [IW-1:0] instr,
  input  logic          instr_valid,
  input  logic          pc_at_limit,
  output logic          pc_ce,
  output logic          pc_down,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [DW-1:0] depth
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [DW-1:0] DEPTH_ONE = DW'(1);
  localparam logic [DW-1:0] DEPTH_MAX = '1;

  state_t        state, state_nxt;
  logic          pc_down_nxt;
  logic          done_nxt;
  logic          error_nxt;
  logic [DW-1:0] depth_nxt;
  logic          nest_in;
  logic          nest_out;

  // A bracket that opens in the scan direction nests deeper; the opposite one unwinds.
  function automatic logic opens_level(input logic [IW-1:0] op, input logic bwd);
    return bwd ? (op == OP_CLOSE) : (op == OP_OPEN);
  endfunction

  function automatic logic closes_level(input logic [IW-1:0] op, input logic bwd);
    return bwd ? (op == OP_OPEN) : (op == OP_CLOSE);
  endfunction

  // Depth saturates instead of wrapping; the caller turns saturation into an error.
  function automatic logic depth_full(input logic [DW-1:0] d);
    return d == DEPTH_MAX;
  endfunction

  assign nest_in  = opens_level(instr, pc_down);
  assign nest_out = closes_level(instr, pc_down);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pc_down <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
      depth   <= '0;
    end else begin
      state   <= state_nxt;
      pc_down <= pc_down_nxt;
      done    <= done_nxt;
      error   <= error_nxt;
      depth   <= depth_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_down_nxt = pc_down;
    done_nxt    = 1'b0;
    error_nxt   = 1'b0;
    depth_nxt   = depth;
    case (state)
      IDLE: begin
        if (start) begin
          pc_down_nxt = dir;
          depth_nxt   = DEPTH_ONE;
          state_nxt   = STEP;
        end
      end
      STEP: begin
        if (abort) begin
          depth_nxt = '0;
          state_nxt = IDLE;
        end else if (pc_at_limit) begin
          error_nxt = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (abort) begin
          depth_nxt = '0;
          state_nxt = IDLE;
        end else if (instr_valid) begin
          if (nest_in) begin
            if (depth_full(depth)) begin
              error_nxt = 1'b1;
              state_nxt = IDLE;
            end else begin
              depth_nxt = depth + DEPTH_ONE;
              state_nxt = STEP;
            end
          end else if (nest_out) begin
            depth_nxt = depth - DEPTH_ONE;
            if (depth == DEPTH_ONE) begin
              done_nxt  = 1'b1;
              state_nxt = IDLE;
            end else begin
              state_nxt = STEP;
            end
          end else begin
            state_nxt = STEP;
          end
        end
      end
      default: begin
        depth_nxt = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // pc_ce is masked by reset and abort so the PC never moves on a cancelled step.
  always_comb begin
    busy  = (state != IDLE);
    pc_ce = (state == STEP) && !pc_at_limit && !abort && !reset;
  end

endmodule

// File: tb/tb_bracket_scan_ctrl.sv
// Scoreboard bench for bracket_scan_ctrl: a PC/program-memory model feeds the DUT,
// a bracket-walking reference predicts each scan's outcome, a monitor checks it.
module tb_bracket_scan_ctrl;
  localparam int IW   = 8;
  localparam int DW   = 3;
  localparam int MAXD = (1 << DW) - 1;
  localparam byte unsigned C_OPEN  = 8'h5B;
  localparam byte unsigned C_CLOSE = 8'h5D;

  logic          clk = 1'b0;
  logic          reset, start, dir, abort, instr_valid, pc_at_limit;
  logic [IW-1:0] instr;
  logic          pc_ce, pc_down, busy, done, error;
  logic [DW-1:0] depth;

  always #5 clk = ~clk;

  bracket_scan_ctrl #(.IW(IW), .DW(DW), .OP_OPEN(8'h5B), .OP_CLOSE(8'h5D)) dut (
    .clk(clk), .reset(reset), .start(start), .dir(dir), .abort(abort),
    .instr(instr), .instr_valid(instr_valid), .pc_at_limit(pc_at_limit),
    .pc_ce(pc_ce), .pc_down(pc_down), .busy(busy), .done(done),
    .error(error), .depth(depth)
  );

  // Program memory and PC Counter model
  byte unsigned prog [0:63];
  int  plen = 1;
  int  pc = 0;
  bit  cur_dir = 1'b0;
  bit  pc_load = 1'b0;
  int  pc_load_val = 0;
  int  lat_max = 0;
  int  cur_lat = 0;
  int  wcnt = 0;

  always @(posedge clk) begin
    if (pc_load) pc <= pc_load_val;
    else if (pc_ce) pc <= cur_dir ? pc - 1 : pc + 1;
    if (pc_ce) begin
      wcnt    <= 0;
      cur_lat <= $urandom_range(lat_max, 0);
    end else if (wcnt < 100) begin
      wcnt <= wcnt + 1;
    end
  end

  assign instr       = (pc >= 0 && pc < 64) ? prog[pc] : '0;
  assign instr_valid = (wcnt >= cur_lat);
  assign pc_at_limit = cur_dir ? (pc == 0) : (pc == plen - 1);

  typedef struct {
    bit done;
    bit err;
    int pc;
    int steps;
    int depth;
    int peak;
    bit dir;
  } exp_t;

  exp_t expq[$];
  exp_t got_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ce_cnt = 0;
  int   peak = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: walk the program counting unmatched brackets until they balance.
  function automatic exp_t model(input int spc, input bit d);
    exp_t e;
    int   p   = spc;
    int   dep = 1;
    e.done = 0; e.err = 0; e.steps = 0; e.peak = 1; e.dir = d;
    for (int guard = 0; guard < 1000; guard++) begin
      if ((d && p == 0) || (!d && p == plen - 1)) begin
        e.err = 1;
        break;
      end
      p = d ? p - 1 : p + 1;
      e.steps++;
      if (prog[p] == (d ? C_CLOSE : C_OPEN)) begin
        if (dep == MAXD) begin
          e.err = 1;
          break;
        end
        dep++;
        if (dep > e.peak) e.peak = dep;
      end else if (prog[p] == (d ? C_OPEN : C_CLOSE)) begin
        dep--;
        if (dep == 0) begin
          e.done = 1;
          break;
        end
      end
    end
    e.pc    = p;
    e.depth = dep;
    return e;
  endfunction

  // Monitor: tallies steps and peak depth per scan, checks each completion pulse.
  always @(negedge clk) begin
    if (!reset) begin
      if (start && !busy) begin
        ce_cnt = 0;
        peak   = 0;
      end else begin
        if (pc_ce) ce_cnt++;
        if (int'(depth) > peak) peak = int'(depth);
      end
      if (done || error) begin
        if (expq.size() == 0) begin
          chk("unexpected_pulse", {30'd0, done, error}, 0);
        end else begin
          got_e = expq.pop_front();
          chk("done",    int'(done),    int'(got_e.done));
          chk("error",   int'(error),   int'(got_e.err));
          chk("pc",      pc,            got_e.pc);
          chk("steps",   ce_cnt,        got_e.steps);
          chk("depth",   int'(depth),   got_e.depth);
          chk("peak",    peak,          got_e.peak);
          chk("pc_down", int'(pc_down), int'(got_e.dir));
          chk("busy",    int'(busy),    0);
        end
      end
    end
  end

  task automatic set_prog(input string s);
    for (int i = 0; i < 64; i++) prog[i] = 8'h00;
    plen = s.len();
    for (int i = 0; i < s.len(); i++) prog[i] = s[i];
  endtask

  task automatic begin_scan(input int spc, input bit d, input int lm);
    @(posedge clk); #1;
    pc_load = 1'b1; pc_load_val = spc; cur_dir = d; lat_max = lm;
    @(posedge clk); #1;
    pc_load = 1'b0;
    start = 1'b1; dir = d;
    expq.push_back(model(spc, d));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_scan(input int spc, input bit d, input int lm, input bit restart);
    begin_scan(spc, d, lm);
    for (int c = 0; ; c++) begin
      if (!busy) break;
      if (c >= 4000) begin
        chk("scan_timeout", 1, 0);
        break;
      end
      if (restart && c == 3) begin
        start = 1'b1; dir = !d;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  // Cancel "[[-]>]" mid-scan by abort or reset after 'after' cycles.
  task automatic cancel_scan(input bit use_reset, input int after);
    int pc_hold;
    set_prog("[[-]>]");
    begin_scan(0, 1'b0, 0);
    void'(expq.pop_back());
    repeat (after) begin @(posedge clk); #1; end
    chk("cancel_busy_before", int'(busy), 1);
    pc_hold = pc;
    if (use_reset) reset = 1'b1; else abort = 1'b1;
    @(negedge clk);
    chk("cancel_pc_ce", int'(pc_ce), 0);
    @(posedge clk); #1;
    reset = 1'b0; abort = 1'b0;
    chk("cancel_busy", int'(busy), 0);
    chk("cancel_done", int'(done), 0);
    chk("cancel_error", int'(error), 0);
    chk("cancel_depth", int'(depth), 0);
    chk("cancel_pc", pc, pc_hold);
    if (use_reset) chk("reset_pc_down", int'(pc_down), 0);
    @(posedge clk); #1;
    chk("cancel_idle_done", int'(done | error), 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; dir = 1'b0; abort = 1'b0;
    set_prog("[]");
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pc_ce", int'(pc_ce), 0);
    chk("rst_pc_down", int'(pc_down), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_depth", int'(depth), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    set_prog("[+-]");           run_scan(0, 1'b0, 0, 1'b0);
    set_prog("[[-]>]");         run_scan(0, 1'b0, 0, 1'b0);
    set_prog("[<[-]]");         run_scan(5, 1'b1, 0, 1'b0);
    set_prog("[++");            run_scan(0, 1'b0, 0, 1'b0);
    set_prog("[+-]");           run_scan(0, 1'b0, 3, 1'b1);
    set_prog("[[[[[[[[]]]]]]]]"); run_scan(0, 1'b0, 1, 1'b0);
    set_prog("]+");             run_scan(0, 1'b1, 0, 1'b0);
    set_prog("[[]]");           run_scan(3, 1'b1, 2, 1'b0);

    cancel_scan(1'b0, 2);
    cancel_scan(1'b0, 3);
    cancel_scan(1'b1, 4);

    for (int n = 0; n < 40; n++) begin
      int len, spc, r;
      bit d;
      len = $urandom_range(24, 4);
      for (int i = 0; i < 64; i++) prog[i] = 8'h00;
      plen = len;
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(9, 0);
        case (r)
          0, 1, 2: prog[i] = C_OPEN;
          3, 4, 5: prog[i] = C_CLOSE;
          6:       prog[i] = 8'h2B;
          7:       prog[i] = 8'h2D;
          8:       prog[i] = 8'h3C;
          default: prog[i] = 8'h3E;
        endcase
      end
      d   = 1'($urandom_range(1, 0));
      spc = $urandom_range(len - 1, 0);
      prog[spc] = d ? C_CLOSE : C_OPEN;
      run_scan(spc, d, $urandom_range(3, 0), ($urandom_range(3, 0) == 0));
    end

    repeat (3) @(posedge clk);
    chk("pending_results", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
